core_wb_arbiter: RTL

// Shares the two register-file write ports between the five execution units fed by dispatch:
// alu_a, alu_b, mul, ldst and branch (link writes).
// ALU results have fixed latency and always win a port.
// mul/ldst/branch compete round-robin for the leftover ports; each has a one-entry holding buffer.

---
 rtl/core_wb_arbiter_pkg.sv | 29 ++
 rtl/core_wb_rr_pick.sv | 36 +++
 rtl/core_wb_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/core_wb_arbiter_pkg.sv
// Shared micro-architectural types for the register-file writeback arbiter.
package core_wb_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int NUM_SLOW  = 3;

    typedef logic [3:0]  reg_num_t;
    typedef logic [31:0] word_t;
    typedef logic [15:0] hword_t;

    // Round-robin requesters, in scan order.
    typedef enum logic [1:0] {
        WB_MUL    = 2'd0,
        WB_LDST   = 2'd1,
        WB_BRANCH = 2'd2
    } slow_idx_e;

    typedef struct packed {
        logic     valid;
        reg_num_t rd;
        word_t    value;
    } wb_result_t;

    // Next slow-unit index, wrapping after branch.
    function automatic logic [1:0] wrap_inc(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/core_wb_rr_pick.sv
// Combinational round-robin picker: grants up to `free` slow requesters
// starting at the pointer, and reports each grant's slot among the free ports.
module core_wb_rr_pick
    import core_wb_arbiter_pkg::*;
(
    input  logic [NUM_SLOW-1:0] req,
    input  slow_idx_e           ptr,
    input  logic [1:0]          free,
    output logic [NUM_SLOW-1:0] grant,
    output logic [NUM_SLOW-1:0] slot,     // 0 = first free port, 1 = second
    output slow_idx_e           next_ptr
);

    logic [1:0] idx;
    logic [1:0] used;

    // Scan three candidates from the pointer, granting while ports remain.
    always_comb begin
        // NOTE: every output and scratch variable gets a default first so no path leaves a latch.
        grant    = '0;
        slot     = '0;
        next_ptr = ptr;
        used     = 2'd0;
        idx      = ptr;
        for (int k = 0; k < NUM_SLOW; k++) begin
            if (req[idx] && (used < free)) begin
                grant[idx] = 1'b1;
                slot[idx]  = used[0];
                used       = used + 2'd1;
                next_ptr   = slow_idx_e'(wrap_inc(idx));
            end
            idx = wrap_inc(idx);
        end
    end

endmodule

// File: rtl/core_wb_arbiter.sv
// Shares two register-file write ports between two fixed-latency ALUs
// (always granted) and three slow units (mul, ldst, branch) that compete
// round-robin for leftover ports, each backed by a one-entry holding buffer.
module core_wb_arbiter
    import core_wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_a_valid,
    input  logic [3:0]  alu_a_rd,
    input  logic [31:0] alu_a_value,
    input  logic        alu_b_valid,
    input  logic [3:0]  alu_b_rd,
    input  logic [31:0] alu_b_value,
    input  logic        mul_valid,
    input  logic [3:0]  mul_rd,
    input  logic [31:0] mul_value,
    input  logic        ldst_valid,
    input  logic [3:0]  ldst_rd,
    input  logic [31:0] ldst_value,
    input  logic        branch_valid,
    input  logic [3:0]  branch_rd,
    input  logic [31:0] branch_value,
    output logic        wb_stall_mul,
    output logic        wb_stall_ldst,
    output logic        wb_stall_branch,
    output logic        wr_en_0,
    output logic [3:0]  wr_r_0,
    output logic [31:0] wr_value_0,
    output logic        wr_en_1,
    output logic [3:0]  wr_r_1,
    output logic [31:0] wr_value_1,
    output logic [15:0] pending_mask
);

    wb_result_t          slow_in [NUM_SLOW];
    wb_result_t          cand    [NUM_SLOW];
    logic [NUM_SLOW-1:0] hold_v_q;
    reg_num_t            hold_rd_q  [NUM_SLOW];
    word_t               hold_val_q [NUM_SLOW];
    logic [NUM_SLOW-1:0] req;
    logic [NUM_SLOW-1:0] grant;
    logic [NUM_SLOW-1:0] slot;
    slow_idx_e           rr_q;
    slow_idx_e           rr_next;
    logic [1:0]          free;
    wb_result_t          port0;
    wb_result_t          port1;

    assign slow_in[WB_MUL]    = '{valid: mul_valid,    rd: mul_rd,    value: mul_value};
    assign slow_in[WB_LDST]   = '{valid: ldst_valid,   rd: ldst_rd,   value: ldst_value};
    assign slow_in[WB_BRANCH] = '{valid: branch_valid, rd: branch_rd, value: branch_value};

    assign free = 2'd2 - {1'b0, alu_a_valid} - {1'b0, alu_b_valid};

    // A buffered result takes precedence; a stalled unit never presents, so only one source exists.
    always_comb begin
        for (int i = 0; i < NUM_SLOW; i++) begin
            cand[i] = hold_v_q[i] ? '{valid: 1'b1, rd: hold_rd_q[i], value: hold_val_q[i]}
                                  : slow_in[i];
            req[i]  = cand[i].valid;
        end
    end

    core_wb_rr_pick u_pick (
        .req      (req),
        .ptr      (rr_q),
        .free     (free),
        .grant    (grant),
        .slot     (slot),
        .next_ptr (rr_next)
    );

    // ALUs own their ports; slow grants fill whichever ports the ALUs left free, port 0 first.
    always_comb begin
        port0 = '{valid: alu_a_valid, rd: alu_a_rd, value: alu_a_value};
        port1 = '{valid: alu_b_valid, rd: alu_b_rd, value: alu_b_value};
        for (int i = 0; i < NUM_SLOW; i++) begin
            if (grant[i]) begin
                if (!slot[i] && !alu_a_valid) port0 = cand[i];
                else                          port1 = cand[i];
            end
        end
    end

    // Write-port enables and the round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            wr_en_0 <= 1'b0;
            wr_en_1 <= 1'b0;
            rr_q    <= WB_MUL;
        end else begin
            wr_en_0 <= port0.valid;
            wr_en_1 <= port1.valid;
            rr_q    <= rr_next;
        end
    end

    // Write-port data holds its last value on idle cycles to avoid toggling.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; their contents are qualified by a reset valid bit.
        if (port0.valid) begin
            wr_r_0     <= port0.rd;
            wr_value_0 <= port0.value;
        end
        if (port1.valid) begin
            wr_r_1     <= port1.rd;
            wr_value_1 <= port1.value;
        end
    end

    // Holding-buffer occupancy: a grant drains it, an unserved new result fills it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_v_q <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOW; i++) begin
                if (grant[i])              hold_v_q[i] <= 1'b0;
                else if (slow_in[i].valid) hold_v_q[i] <= 1'b1;
            end
        end
    end

    // Holding-buffer payload captured alongside occupancy.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_SLOW; i++) begin
            if (!grant[i] && slow_in[i].valid) begin
                hold_rd_q[i]  <= slow_in[i].rd;
                hold_val_q[i] <= slow_in[i].value;
            end
        end
    end

    // Destinations of buffered writes, for dispatch hazard checks.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_SLOW; i++) begin
            if (hold_v_q[i]) pending_mask = pending_mask | (hword_t'(1) << hold_rd_q[i]);
        end
    end

    assign wb_stall_mul    = hold_v_q[WB_MUL];
    assign wb_stall_ldst   = hold_v_q[WB_LDST];
    assign wb_stall_branch = hold_v_q[WB_BRANCH];

endmodule
